// File: rtl/spi_phy_pkg.sv
// Shared definitions for the spi-phy block (RX and TX PHYs).
// Byte/bit-counter widths, the default frame-index width, SPI mode
// encoding and Gray-code helpers for the bit-counter crossing.
package spi_phy_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam int CNT_W_DEF = 24;

  // SPI mode number: bit 1 = clock polarity, bit 0 = sampling phase.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  localparam int MODE_ACTIVE_BIT = 1;
  localparam int MODE_PHASE_BIT  = 0;

  function automatic logic [BIT_CNT_W-1:0] bin2gray(input logic [BIT_CNT_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [BIT_CNT_W-1:0] gray2bin(input logic [BIT_CNT_W-1:0] gray);
    logic [BIT_CNT_W-1:0] bin;
    bin[BIT_CNT_W-1] = gray[BIT_CNT_W-1];
    for (int i = BIT_CNT_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rx_8bit_phy_if.sv
// Received-byte bus of the SPI slave RX PHY (system clock domain).
// master: the PHY driving bytes and frame events; slave: the consumer.
interface rx_8bit_phy_if
  import spi_phy_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic [CNT_W-1:0]  rx_index;
  logic              frame_active;
  logic              frame_end;
  logic              frame_err;

  modport master (
    output rx_data, rx_valid, rx_index, frame_active, frame_end, frame_err
  );

  modport slave (
    input rx_data, rx_valid, rx_index, frame_active, frame_end, frame_err
  );

endinterface

// File: rtl/cross_clk_sync.sv
// Multi-flop synchroniser into the destination clock domain.
// Multi-bit use is only safe for Gray-coded or quasi-static inputs.
module cross_clk_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/edge_generator.sv
// Rise/fall detector for an already-synchronous level.
// The reset value of the history flop sets which level counts as "idle".
module edge_generator #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_r;

  // Remember last cycle's level.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= RST_VAL;
    end else begin
      prev_r <= d;
    end
  end

  assign rise = d & ~prev_r;
  assign fall = ~d & prev_r;

endmodule

// File: rtl/rx_shift_core.sv
// Trigger-domain half of the SPI slave RX PHY: deserialises MOSI into
// bytes, parks each completed byte in hold and flips byte_tgl.
// With RX_FRAME_ERR_EN defined it also publishes a Gray-coded bit count.
module rx_shift_core
  import spi_phy_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 trigger_clock,
  input  logic                 trigger_rst_n,
  input  logic                 mosi,
`ifdef RX_FRAME_ERR_EN
  output logic [BIT_CNT_W-1:0] bit_cnt_gray,
`endif
  output logic [BYTE_W-1:0]    hold,
  output logic                 byte_tgl
);

  logic [BYTE_W-2:0]    shift_r;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [BYTE_W-1:0]    hold_r;
  logic                 byte_tgl_r;
  logic [BYTE_W-2:0]    next_shift_s;
  logic [BYTE_W-1:0]    next_byte_s;

  // Shift direction: MSB-first pushes up so the first bit ends in bit 7,
  // LSB-first pushes down so the first bit ends in bit 0.
  always_comb begin
    next_shift_s = '0;
    next_byte_s  = '0;
    if (MSB_FIRST) begin
      next_shift_s = {shift_r[BYTE_W-3:0], mosi};
      next_byte_s  = {shift_r, mosi};
    end else begin
      next_shift_s = {mosi, shift_r[BYTE_W-2:1]};
      next_byte_s  = {mosi, shift_r};
    end
  end

  // Shift register, bit counter and completion toggle; cleared whenever
  // the frame ends so a partial byte is simply dropped.
  always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
    if (!trigger_rst_n) begin
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      byte_tgl_r <= 1'b0;
    end else begin
      shift_r   <= next_shift_s;
      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        byte_tgl_r <= ~byte_tgl_r;
      end else begin
        byte_tgl_r <= byte_tgl_r;
      end
    end
  end

  // Completed byte; deliberately not reset so the clock domain can still
  // read it while the toggle edge is in flight.
  always_ff @(posedge trigger_clock) begin
    if (bit_cnt_r == 3'd7) begin
      hold_r <= next_byte_s;
    end else begin
      hold_r <= hold_r;
    end
  end

`ifdef RX_FRAME_ERR_EN
  logic [BIT_CNT_W-1:0] gray_r;

  // Registered Gray copy of the post-edge bit count, one bit changing per edge.
  always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
    if (!trigger_rst_n) begin
      gray_r <= '0;
    end else begin
      gray_r <= bin2gray(bit_cnt_r + 3'd1);
    end
  end

  assign bit_cnt_gray = gray_r;
`endif

  assign hold     = hold_r;
  assign byte_tgl = byte_tgl_r;

endmodule

// File: rtl/rx_8bit_phy.sv
// SPI slave receive PHY: trigger-domain deserialiser plus the transfer of
// each byte into the system clock domain as a one-cycle indexed pulse.
// Optional feature macro: RX_FRAME_ERR_EN (partial-byte detection at frame end).
module rx_8bit_phy
  import spi_phy_pkg::*;
#(
  parameter bit MSB_FIRST   = 1'b1,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          trigger_clock,
  input  logic          trigger_rst_n,
  input  logic          clock,
  input  logic          rst_n,
  input  logic          mosi,
  input  logic          cs_n,
  rx_8bit_phy_if.master rx_bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BYTE_W-1:0] hold_s;
  logic              byte_tgl_s;
  logic              cs_sync_s;
  logic              tgl_sync_s;
  logic              cs_rise_s;
  logic              cs_fall_s;
  logic              tgl_rise_s;
  logic              tgl_fall_s;
  logic              byte_pulse_s;

  logic [BYTE_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic [CNT_W-1:0]  rx_index_r;
  logic [CNT_W-1:0]  count_r;
  logic              frame_active_r;
  logic              frame_end_r;

`ifdef RX_FRAME_ERR_EN
  logic [BIT_CNT_W-1:0] bit_cnt_gray_s;
  logic [BIT_CNT_W-1:0] gray_sync_s;
  logic [BIT_CNT_W-1:0] last_cnt_r;
  logic                 frame_err_r;
`endif

  rx_shift_core #(
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .trigger_clock(trigger_clock),
    .trigger_rst_n(trigger_rst_n),
    .mosi         (mosi),
`ifdef RX_FRAME_ERR_EN
    .bit_cnt_gray (bit_cnt_gray_s),
`endif
    .hold         (hold_s),
    .byte_tgl     (byte_tgl_s)
  );

  cross_clk_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clock(clock), .rst_n(rst_n), .d(cs_n), .q(cs_sync_s)
  );

  cross_clk_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_tgl_sync (
    .clock(clock), .rst_n(rst_n), .d(byte_tgl_s), .q(tgl_sync_s)
  );

  edge_generator #(.RST_VAL(1'b1)) u_cs_edge (
    .clock(clock), .rst_n(rst_n), .d(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  edge_generator #(.RST_VAL(1'b0)) u_tgl_edge (
    .clock(clock), .rst_n(rst_n), .d(tgl_sync_s), .rise(tgl_rise_s), .fall(tgl_fall_s)
  );

  // A toggle change is a byte only inside a frame. The registered
  // frame_active masks the toggle resynchronising after rst_n, and the
  // live synchronised cs_n masks the toggle's return to 0 at frame end.
  assign byte_pulse_s = (tgl_rise_s | tgl_fall_s) & frame_active_r & ~cs_sync_s;

  // Registered byte delivery, frame-level status and in-frame byte counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r      <= '0;
      rx_valid_r     <= 1'b0;
      rx_index_r     <= '0;
      count_r        <= '0;
      frame_active_r <= 1'b0;
      frame_end_r    <= 1'b0;
    end else begin
      frame_active_r <= ~cs_sync_s;
      frame_end_r    <= cs_rise_s;
      rx_valid_r     <= byte_pulse_s;
      if (byte_pulse_s) begin
        rx_data_r  <= hold_s;
        rx_index_r <= count_r;
      end else begin
        rx_data_r  <= rx_data_r;
        rx_index_r <= rx_index_r;
      end
      if (cs_fall_s) begin
        count_r <= '0;
      end else if (byte_pulse_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

`ifdef RX_FRAME_ERR_EN
  cross_clk_sync #(.WIDTH(BIT_CNT_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_gray_sync (
    .clock(clock), .rst_n(rst_n), .d(bit_cnt_gray_s), .q(gray_sync_s)
  );

  // Sample the bit count while the frame is open; a non-zero count at the
  // cs_n rise means the frame ended mid-byte.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_cnt_r  <= '0;
      frame_err_r <= 1'b0;
    end else begin
      if (!cs_sync_s) begin
        last_cnt_r <= gray2bin(gray_sync_s);
      end else begin
        last_cnt_r <= last_cnt_r;
      end
      frame_err_r <= cs_rise_s && (last_cnt_r != 3'd0);
    end
  end

  assign rx_bus.frame_err = frame_err_r;
`else
  assign rx_bus.frame_err = 1'b0;
`endif

  assign rx_bus.rx_data      = rx_data_r;
  assign rx_bus.rx_valid     = rx_valid_r;
  assign rx_bus.rx_index     = rx_index_r;
  assign rx_bus.frame_active = frame_active_r;
  assign rx_bus.frame_end    = frame_end_r;

endmodule

// File: tb/tb_rx_8bit_phy.sv
// Self-checking bench for rx_8bit_phy: one MSB-first and one LSB-first
// instance share the serial inputs; a scoreboard queue per instance holds
// the expected bytes, popped on every rx_valid.
`timescale 1ns/1ps
module tb_rx_8bit_phy;
  import spi_phy_pkg::*;

  localparam int CNT_W = 24;
`ifdef RX_FRAME_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n;
  logic trigger_clock;
  logic trigger_rst_n;
  logic mosi;
  logic cs_n;

  assign trigger_rst_n = ~cs_n;

  always #5 clock = ~clock;

  rx_8bit_phy_if #(.CNT_W(CNT_W)) bus_m ();
  rx_8bit_phy_if #(.CNT_W(CNT_W)) bus_l ();

  rx_8bit_phy #(.MSB_FIRST(1'b1), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut_m (
    .trigger_clock(trigger_clock), .trigger_rst_n(trigger_rst_n), .clock(clock),
    .rst_n(rst_n), .mosi(mosi), .cs_n(cs_n), .rx_bus(bus_m)
  );

  rx_8bit_phy #(.MSB_FIRST(1'b0), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut_l (
    .trigger_clock(trigger_clock), .trigger_rst_n(trigger_rst_n), .clock(clock),
    .rst_n(rst_n), .mosi(mosi), .cs_n(cs_n), .rx_bus(bus_l)
  );

  typedef struct packed {
    logic [7:0]       data;
    logic [CNT_W-1:0] index;
  } exp_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    int         extra;
    bit         lsb;
    logic       err;
    int         gap;
  } vec_t;

  exp_t q_m[$];
  exp_t q_l[$];
  int   tests = 0;
  int   fails = 0;
  int   fe_cnt = 0;
  logic exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit lsb, input int idx);
    exp_t e;
    e.index = CNT_W'(idx);
    e.data  = lsb ? rev8(b) : b;
    q_m.push_back(e);
    e.data  = lsb ? b : rev8(b);
    q_l.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit lsb, input realtime half);
    for (int i = 0; i < nbits; i++) begin
      mosi = lsb ? b[i] : b[7-i];
      #(half) trigger_clock = 1'b1;
      #(half) trigger_clock = 1'b0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_m.rx_valid) begin
        check("queue_nonempty_m", 32'(q_m.size() != 0), 32'd1);
        if (q_m.size() != 0) begin
          e = q_m.pop_front();
          check("rx_data_m", 32'(bus_m.rx_data), 32'(e.data));
          check("rx_index_m", 32'(bus_m.rx_index), 32'(e.index));
        end
      end
      if (bus_l.rx_valid) begin
        check("queue_nonempty_l", 32'(q_l.size() != 0), 32'd1);
        if (q_l.size() != 0) begin
          e = q_l.pop_front();
          check("rx_data_l", 32'(bus_l.rx_data), 32'(e.data));
          check("rx_index_l", 32'(bus_l.rx_index), 32'(e.index));
        end
      end
      if (bus_m.frame_end || bus_m.frame_err) begin
        if (bus_m.frame_end) fe_cnt++;
        check("err_with_end", 32'(bus_m.frame_end), 32'd1);
        check("delivered_by_end", 32'(q_m.size()), 32'd0);
        check("frame_err", 32'(bus_m.frame_err), 32'(exp_err));
        check("frame_err_l", 32'(bus_l.frame_err), 32'(exp_err));
      end
    end
  endtask

  task automatic wait_frame_end(input int gap_ns);
    int start;
    int k;
    start = fe_cnt;
    k = 0;
    while (fe_cnt == start && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("frame_end_seen", 32'(fe_cnt - start), 32'd1);
    if (gap_ns > 0) begin
      #(gap_ns);
      check("frame_end_once", 32'(fe_cnt - start), 32'd1);
    end
  endtask

  task automatic open_frame();
    cs_n = 1'b0;
    repeat (4) @(negedge clock);
    check("frame_active_open", 32'(bus_m.frame_active), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] b;
    exp_err = v.err;
    open_frame();
    for (int i = 0; i < v.nbytes; i++) begin
      b = (i == 0) ? v.b0 : v.b1;
      push_byte(b, v.lsb, i);
      send_bits(b, 8, v.lsb, 20.0);
    end
    if (v.extra > 0) send_bits(v.b1, v.extra, v.lsb, 20.0);
    #60;
    cs_n = 1'b1;
    wait_frame_end(v.gap);
  endtask

  vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{b0: 8'hA5, b1: 8'h3C, nbytes: 2, extra: 0, lsb: 1'b0, err: 1'b0,   gap: 50};
    vecs[1] = '{b0: 8'hA5, b1: 8'h00, nbytes: 1, extra: 0, lsb: 1'b1, err: 1'b0,   gap: 50};
    vecs[2] = '{b0: 8'h5A, b1: 8'hE8, nbytes: 1, extra: 5, lsb: 1'b0, err: ERR_EN, gap: 0};
    vecs[3] = '{b0: 8'h01, b1: 8'h00, nbytes: 1, extra: 0, lsb: 1'b0, err: 1'b0,   gap: 50};
    vecs[4] = '{b0: 8'h1E, b1: 8'hC3, nbytes: 2, extra: 0, lsb: 1'b1, err: 1'b0,   gap: 50};

    rst_n = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    trigger_clock = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock);
    check("rst_rx_data", 32'(bus_m.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus_m.rx_valid), 32'd0);
    check("rst_rx_index", 32'(bus_m.rx_index), 32'd0);
    check("rst_frame_active", 32'(bus_m.frame_active), 32'd0);
    check("rst_frame_end", 32'(bus_m.frame_end), 32'd0);
    check("rst_frame_err", 32'(bus_m.frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_frame_active", 32'(bus_m.frame_active), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
    end

    // rst_n pulsed mid-frame between two bytes.
    exp_err = 1'b0;
    open_frame();
    push_byte(8'h77, 1'b0, 0);
    send_bits(8'h77, 8, 1'b0, 20.0);
    repeat (8) @(negedge clock);
    check("queue_drained_77", 32'(q_m.size()), 32'd0);
    rst_n = 1'b0;
    @(negedge clock);
    check("midrst_rx_data", 32'(bus_m.rx_data), 32'd0);
    check("midrst_rx_valid", 32'(bus_m.rx_valid), 32'd0);
    check("midrst_rx_index", 32'(bus_m.rx_index), 32'd0);
    check("midrst_frame_active", 32'(bus_m.frame_active), 32'd0);
    check("midrst_rx_data_l", 32'(bus_l.rx_data), 32'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (6) @(negedge clock);
    check("postrst_frame_active", 32'(bus_m.frame_active), 32'd1);
    check("postrst_rx_data", 32'(bus_m.rx_data), 32'd0);
    push_byte(8'h88, 1'b0, 0);
    send_bits(8'h88, 8, 1'b0, 20.0);
    #60;
    cs_n = 1'b1;
    wait_frame_end(50);

    // sck at the clock/sck = 1.5 limit, 256 incrementing bytes.
    exp_err = 1'b0;
    open_frame();
    for (int i = 0; i < 256; i++) begin
      push_byte(8'(i), 1'b0, i);
      send_bits(8'(i), 8, 1'b0, 7.5);
    end
    #60;
    cs_n = 1'b1;
    wait_frame_end(50);
    check("all_bytes_delivered_m", 32'(q_m.size()), 32'd0);
    check("all_bytes_delivered_l", 32'(q_l.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
